pay_validator_fsm: RTL and testbench

//  Parametrised successor to the single-compare payment check. Accumulates coins into a credit

---
 rtl/pay_validator_fsm.sv | 136 +++++++++++++
 tb/tb_pay_validator_fsm.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pay_validator_fsm.sv
// Payment validator: accumulates coin credit, checks a selected price and hands the vend/refund result to the dispenser.
// Optional feature macro: PAY_TIMEOUT_EN (auto-refund after TIMEOUT_CYC idle cycles in COLLECT).
module pay_validator_fsm #(
    parameter int AMT_W       = 8,
    parameter int PRICE_W     = 6,
    parameter int COIN_W      = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_valid,
    input  logic [COIN_W-1:0]  coin_val,
    output logic               coin_ready,
    input  logic               sel_valid,
    input  logic [PRICE_W-1:0] price,
    input  logic               cancel,
    input  logic               out_ready,
    output logic               vend_valid,
    output logic               refund_valid,
    output logic [AMT_W-1:0]   change,
    output logic [AMT_W-1:0]   credit,
    output logic               short_err,
    output logic               ovf_err
);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

    state_t           state, state_n;
    logic [AMT_W-1:0] credit_n, change_n;
    logic             vend_n, refund_n, short_n, ovf_n, ready_n;
    logic [AMT_W:0]   sum;
    logic [AMT_W-1:0] price_ext;
    logic             coin_take, coin_acc, tmo;

    // Carry bit of sum flags a coin that would overflow the credit register.
    assign sum       = {1'b0, credit} + (AMT_W+1)'(coin_val);
    assign price_ext = AMT_W'(price);
    assign coin_take = coin_valid & coin_ready & ~cancel & ~sel_valid;
    assign coin_acc  = coin_take & ~sum[AMT_W];

`ifdef PAY_TIMEOUT_EN
    localparam int             TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] timer, timer_n;

    // Down-counter loaded on COLLECT entry and on every coin/short event; zero means expired.
    assign tmo = (timer == '0);

    always_comb begin
        timer_n = timer;
        if (state_n != COLLECT)
            timer_n = '0;
        else if (state != COLLECT || coin_acc || short_n)
            timer_n = TMR_LOAD;
        else
            timer_n = timer - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) timer <= '0;
        else     timer <= timer_n;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        credit_n = credit;
        change_n = change;
        short_n  = 1'b0;
        ovf_n    = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (cancel && state == COLLECT) begin
                    change_n = credit;
                    state_n  = REFUND;
                end else if (sel_valid) begin
                    if (credit >= price_ext) begin
                        change_n = credit - price_ext;
                        state_n  = VEND;
                    end else begin
                        short_n = 1'b1;
                    end
                end else if (coin_take) begin
                    if (state == IDLE) begin
                        credit_n = AMT_W'(coin_val);
                        state_n  = COLLECT;
                    end else if (sum[AMT_W]) begin
                        ovf_n = 1'b1;
                    end else begin
                        credit_n = sum[AMT_W-1:0];
                    end
                end else if (tmo && state == COLLECT) begin
                    change_n = credit;
                    state_n  = REFUND;
                end
            end
            VEND, REFUND: begin
                if (out_ready) begin
                    credit_n = '0;
                    change_n = '0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        vend_n   = (state_n == VEND);
        refund_n = (state_n == REFUND);
        ready_n  = (state_n == IDLE) || (state_n == COLLECT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            credit       <= '0;
            change       <= '0;
            vend_valid   <= 1'b0;
            refund_valid <= 1'b0;
            short_err    <= 1'b0;
            ovf_err      <= 1'b0;
            coin_ready   <= 1'b0;
        end else begin
            state        <= state_n;
            credit       <= credit_n;
            change       <= change_n;
            vend_valid   <= vend_n;
            refund_valid <= refund_n;
            short_err    <= short_n;
            ovf_err      <= ovf_n;
            coin_ready   <= ready_n;
        end
    end

endmodule

// File: tb/tb_pay_validator_fsm.sv
// Directed self-checking bench for pay_validator_fsm; honours PAY_TIMEOUT_EN with TIMEOUT_CYC=20.
module tb_pay_validator_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [3:0] coin_val;
    logic       coin_ready;
    logic       sel_valid;
    logic [5:0] price;
    logic       cancel;
    logic       out_ready;
    logic       vend_valid;
    logic       refund_valid;
    logic [7:0] change;
    logic [7:0] credit;
    logic       short_err;
    logic       ovf_err;

    int compared   = 0;
    int mismatched = 0;

    pay_validator_fsm #(.AMT_W(8), .PRICE_W(6), .COIN_W(4), .TIMEOUT_CYC(20)) dut (
        .clk(clk), .rst(rst),
        .coin_valid(coin_valid), .coin_val(coin_val), .coin_ready(coin_ready),
        .sel_valid(sel_valid), .price(price), .cancel(cancel), .out_ready(out_ready),
        .vend_valid(vend_valid), .refund_valid(refund_valid),
        .change(change), .credit(credit),
        .short_err(short_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; out_ready = 1'b0;
    endtask

    task automatic outs(input string tag, input logic [7:0] cr, input logic [7:0] ch,
                        input logic vv, input logic rv, input logic rdy);
        chk({tag, "_credit"}, 32'(credit), 32'(cr));
        chk({tag, "_change"}, 32'(change), 32'(ch));
        chk({tag, "_vend"},   32'(vend_valid), 32'(vv));
        chk({tag, "_refund"}, 32'(refund_valid), 32'(rv));
        chk({tag, "_ready"},  32'(coin_ready), 32'(rdy));
    endtask

    initial begin
        rst = 1'b1; coin_val = '0; price = '0;
        idle_in();
        #12;
        outs("reset", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("reset_short", 32'(short_err), 32'd0);
        chk("reset_ovf", 32'(ovf_err), 32'd0);
        rst = 1'b0;
        step();
        chk("ready_after_reset", 32'(coin_ready), 32'd1);

        // coins 5,5 then price 7
        coin_valid = 1'b1; coin_val = 4'd5;
        step(); chk("coin5_credit", 32'(credit), 32'd5);
        step(); chk("coin55_credit", 32'(credit), 32'd10);
        coin_valid = 1'b0; sel_valid = 1'b1; price = 6'd7;
        step(); outs("vend7", 8'd10, 8'd3, 1'b1, 1'b0, 1'b0);
        idle_in(); coin_valid = 1'b1; cancel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); outs("vend7_hold", 8'd10, 8'd3, 1'b1, 1'b0, 1'b0);
        end
        idle_in(); out_ready = 1'b1;
        step(); outs("vend7_done", 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        idle_in();

        // short selection then top up
        coin_valid = 1'b1; coin_val = 4'd3;
        step(); chk("coin3_credit", 32'(credit), 32'd3);
        coin_valid = 1'b0; sel_valid = 1'b1; price = 6'd5;
        step();
        chk("short_pulse", 32'(short_err), 32'd1);
        outs("short", 8'd3, 8'd0, 1'b0, 1'b0, 1'b1);
        sel_valid = 1'b0;
        step(); chk("short_drop", 32'(short_err), 32'd0);
        coin_valid = 1'b1; coin_val = 4'd2;
        step(); chk("coin2_credit", 32'(credit), 32'd5);
        coin_valid = 1'b0; sel_valid = 1'b1;
        step(); outs("vend5", 8'd5, 8'd0, 1'b1, 1'b0, 1'b0);
        idle_in(); out_ready = 1'b1;
        step(); outs("vend5_done", 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        idle_in();

        // cancel with same-cycle coin
        coin_valid = 1'b1; coin_val = 4'd9;
        step(); chk("coin9_credit", 32'(credit), 32'd9);
        cancel = 1'b1;
        step(); outs("refund9", 8'd9, 8'd9, 1'b0, 1'b1, 1'b0);
        idle_in(); out_ready = 1'b1;
        step(); outs("refund9_done", 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        idle_in();

        // overflow boundary: 16*15 + 10 = 250
        coin_valid = 1'b1; coin_val = 4'd15;
        for (int i = 0; i < 16; i++) step();
        coin_val = 4'd10;
        step(); chk("credit250", 32'(credit), 32'd250);
        coin_val = 4'd15;
        step();
        chk("ovf_pulse", 32'(ovf_err), 32'd1);
        chk("ovf_credit", 32'(credit), 32'd250);
        coin_val = 4'd5;
        step();
        chk("ovf_drop", 32'(ovf_err), 32'd0);
        chk("credit255", 32'(credit), 32'd255);
        coin_valid = 1'b0; cancel = 1'b1;
        step(); outs("refund255", 8'd255, 8'd255, 1'b0, 1'b1, 1'b0);
        idle_in(); out_ready = 1'b1;
        step(); idle_in();

        // price 0 vend, then reset while waiting
        coin_valid = 1'b1; coin_val = 4'd4;
        step();
        coin_valid = 1'b0; sel_valid = 1'b1; price = 6'd0;
        step(); outs("vend0", 8'd4, 8'd4, 1'b1, 1'b0, 1'b0);
        idle_in();
        #2 rst = 1'b1;
        #1 outs("async_rst", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        step(); outs("post_rst", 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);

        // timeout behaviour
        coin_valid = 1'b1; coin_val = 4'd4;
        step(); chk("tmo_coin", 32'(credit), 32'd4);
        coin_valid = 1'b0;
`ifdef PAY_TIMEOUT_EN
        for (int i = 0; i < 19; i++) step();
        chk("tmo_early", 32'(refund_valid), 32'd0);
        step(); outs("tmo_refund", 8'd4, 8'd4, 1'b0, 1'b1, 1'b0);
`else
        for (int i = 0; i < 100; i++) step();
        outs("no_tmo", 8'd4, 8'd0, 1'b0, 1'b0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
